// File: rtl/bitfuscnn_pkg.sv
// Shared types for the halo exchange engine: coordinates, halo entries and FSM states.
package bitfuscnn_pkg;
  localparam int HALO_TILE_SIZE  = 256;
  localparam int HALO_CW         = $clog2(HALO_TILE_SIZE);
  localparam int HALO_DATA_WIDTH = 8;

  typedef logic [HALO_CW-1:0] coord_t;

  typedef struct packed {
    logic [HALO_DATA_WIDTH-1:0] value;
    coord_t                     row;
    coord_t                     column;
  } halo_entry_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    WAIT_PEERS = 2'd2,
    DONE       = 2'd3
  } halo_state_e;
endpackage

// File: rtl/halo_fifo.sv
// Synchronous FIFO for one neighbour link; pointers carry an extra wrap bit.
module halo_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/halo_exchange.sv
// Per-PE halo exchange: buffers halo entries per neighbour, drains them under
// clear-to-send, then waits for all present neighbours before pulsing cycle_done.
module halo_exchange
  import bitfuscnn_pkg::*;
#(
  parameter int                        TILE_SIZE      = 256,
  parameter int                        NEIGHBOR_COUNT = 8,
  parameter int                        DATA_WIDTH     = 8,
  parameter int                        FIFO_DEPTH     = 16,
  parameter logic [NEIGHBOR_COUNT-1:0] NEIGHBOR_MASK  = '1,
  localparam int                       CW             = $clog2(TILE_SIZE),
  localparam int                       DW             = $clog2(NEIGHBOR_COUNT)
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       enq_valid,
  input  logic [DW-1:0]                              enq_dir,
  input  logic [DATA_WIDTH-1:0]                      enq_value,
  input  logic [CW-1:0]                              enq_row,
  input  logic [CW-1:0]                              enq_column,
  output logic                                       enq_ready,
  input  logic                                       flush,
  input  logic [NEIGHBOR_COUNT-1:0]                  neighbor_cts,
  input  logic [NEIGHBOR_COUNT-1:0]                  neighbor_exchange_done,
  output logic                                       clear_to_send,
  output logic                                       exchange_done,
  output logic                                       cycle_done,
  output logic [NEIGHBOR_COUNT-1:0][DATA_WIDTH-1:0]  neighbor_output_value,
  output logic [NEIGHBOR_COUNT-1:0][CW-1:0]          neighbor_output_row,
  output logic [NEIGHBOR_COUNT-1:0][CW-1:0]          neighbor_output_column,
  output logic [NEIGHBOR_COUNT-1:0]                  neighbor_output_write_enable,
  output logic                                       dropped
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic [CW-1:0]         row;
    logic [CW-1:0]         column;
  } entry_t;
  localparam int EW = $bits(entry_t);

  halo_state_e                               r_state;
  logic                                      r_cts;
  logic                                      r_xdone;
  logic                                      r_cdone;
  logic                                      r_dropped;
  logic [NEIGHBOR_COUNT-1:0]                 r_we;
  logic [NEIGHBOR_COUNT-1:0][DATA_WIDTH-1:0] r_val;
  logic [NEIGHBOR_COUNT-1:0][CW-1:0]         r_row;
  logic [NEIGHBOR_COUNT-1:0][CW-1:0]         r_col;

  entry_t                                    w_enq_entry;
  logic                                      w_sel_present;
  logic                                      w_accept;
  logic                                      w_all_empty;
  logic                                      w_peers_done;
  logic [NEIGHBOR_COUNT-1:0]                 w_push;
  logic [NEIGHBOR_COUNT-1:0]                 w_pop;
  logic [NEIGHBOR_COUNT-1:0]                 w_full;
  logic [NEIGHBOR_COUNT-1:0]                 w_empty;
  logic [NEIGHBOR_COUNT-1:0][EW-1:0]         w_dout;

  assign w_enq_entry   = '{value: enq_value, row: enq_row, column: enq_column};
  assign w_sel_present = NEIGHBOR_MASK[enq_dir];
  assign enq_ready     = (r_state == IDLE) && (!w_sel_present || !w_full[enq_dir]);
  assign w_accept      = enq_valid && enq_ready;
  assign w_all_empty   = &w_empty;
  // Absent links behave as permanently done so tile-edge PEs never stall.
  assign w_peers_done  = &(neighbor_exchange_done | ~NEIGHBOR_MASK);

  for (genvar g = 0; g < NEIGHBOR_COUNT; g++) begin : g_link
    assign w_push[g] = w_accept && w_sel_present && (enq_dir == DW'(g));
    assign w_pop[g]  = (r_state == DRAIN) && NEIGHBOR_MASK[g] && !w_empty[g] && neighbor_cts[g];

    halo_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push[g]),
      .i_din   (w_enq_entry),
      .i_pop   (w_pop[g]),
      .o_dout  (w_dout[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cts   <= 1'b0;
      r_xdone <= 1'b0;
      r_cdone <= 1'b0;
    end else begin
      r_cdone <= 1'b0;
      case (r_state)
        IDLE: if (flush) begin
          r_state <= DRAIN;
          r_cts   <= 1'b1;
        end
        // Empty FIFOs imply no pop this cycle, so no write is left in flight.
        DRAIN: if (w_all_empty) begin
          r_state <= WAIT_PEERS;
          r_xdone <= 1'b1;
        end
        WAIT_PEERS: if (w_peers_done) begin
          r_state <= DONE;
          r_cts   <= 1'b0;
          r_cdone <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_xdone <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we      <= '0;
      r_val     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_we <= w_pop;
      for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
        if (w_pop[i]) {r_val[i], r_row[i], r_col[i]} <= w_dout[i];
      end
      if (w_accept && !w_sel_present) r_dropped <= 1'b1;
    end
  end

  assign clear_to_send                = r_cts;
  assign exchange_done                = r_xdone;
  assign cycle_done                   = r_cdone;
  assign dropped                      = r_dropped;
  assign neighbor_output_write_enable = r_we;
  assign neighbor_output_value        = r_val;
  assign neighbor_output_row          = r_row;
  assign neighbor_output_column       = r_col;
endmodule

// File: tb/tb_halo_exchange.sv
// Bench for halo_exchange: full-mask instance with a per-link scoreboard, plus an edge-PE instance.
module tb_halo_exchange;
  import bitfuscnn_pkg::*;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic            enq_valid, enq_ready, flush;
  logic [2:0]      enq_dir;
  logic [7:0]      enq_value, enq_row, enq_column;
  logic [N-1:0]    cts, pdone, o_we;
  logic            clear_to_send, exchange_done, cycle_done, dropped;
  logic [N-1:0][7:0] o_val, o_row, o_col;

  logic            m_enq_valid, m_enq_ready, m_flush;
  logic [2:0]      m_enq_dir;
  logic [N-1:0]    m_cts, m_done, m_we;
  logic            m_cts_out, m_xdone, m_cdone, m_dropped;
  logic [N-1:0][7:0] m_val, m_row, m_col;

  halo_exchange u_dut (
    .clk(clk), .reset_n(reset_n), .enq_valid(enq_valid), .enq_dir(enq_dir),
    .enq_value(enq_value), .enq_row(enq_row), .enq_column(enq_column), .enq_ready(enq_ready),
    .flush(flush), .neighbor_cts(cts), .neighbor_exchange_done(pdone),
    .clear_to_send(clear_to_send), .exchange_done(exchange_done), .cycle_done(cycle_done),
    .neighbor_output_value(o_val), .neighbor_output_row(o_row), .neighbor_output_column(o_col),
    .neighbor_output_write_enable(o_we), .dropped(dropped)
  );

  halo_exchange #(.NEIGHBOR_MASK(8'hFE)) u_dut_m (
    .clk(clk), .reset_n(reset_n), .enq_valid(m_enq_valid), .enq_dir(m_enq_dir),
    .enq_value(8'h77), .enq_row(8'h01), .enq_column(8'h02), .enq_ready(m_enq_ready),
    .flush(m_flush), .neighbor_cts(m_cts), .neighbor_exchange_done(m_done),
    .clear_to_send(m_cts_out), .exchange_done(m_xdone), .cycle_done(m_cdone),
    .neighbor_output_value(m_val), .neighbor_output_row(m_row), .neighbor_output_column(m_col),
    .neighbor_output_write_enable(m_we), .dropped(m_dropped)
  );

  typedef struct packed { logic [2:0] dir; halo_entry_t e; } sb_item_t;
  sb_item_t     sbq[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           wr_cnt0 = 0;
  int           m_cd_cnt = 0;
  logic         m_w0_seen = 1'b0;
  logic [N-1:0] cts_at_edge;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cts_at_edge <= cts;

  // Each write must follow a cts=1 cycle and match the oldest expected entry for that link.
  always @(negedge clk) begin
    int idx;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (o_we[i]) begin
          idx = -1;
          for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].dir == i[2:0]) idx = k;
          chk($sformatf("wr_cts%0d", i), {31'd0, cts_at_edge[i]}, 32'd1);
          chk($sformatf("sb_hit%0d", i), {31'd0, (idx >= 0)}, 32'd1);
          if (idx >= 0) begin
            chk($sformatf("wr_data%0d", i), {8'd0, o_val[i], o_row[i], o_col[i]}, {8'd0, sbq[idx].e});
            sbq.delete(idx);
          end
          if (i == 0) wr_cnt0++;
        end
      end
      if (m_we[0]) m_w0_seen = 1'b1;
      if (m_cdone) m_cd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic [2:0] d, input logic [7:0] v, input logic [7:0] r,
                     input logic [7:0] c, output logic acc);
    enq_valid = 1'b1; enq_dir = d; enq_value = v; enq_row = r; enq_column = c;
    #1;
    acc = enq_ready;
    if (acc) sbq.push_back({d, v, r, c});
    tick();
    enq_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   k, base;
    reset_n = 1'b0; enq_valid = 0; enq_dir = 0; enq_value = 0; enq_row = 0; enq_column = 0;
    flush = 0; cts = '1; pdone = '1;
    m_enq_valid = 0; m_enq_dir = 0; m_flush = 0; m_cts = '1; m_done = 8'hFE;
    tick(); tick();

    // reset state
    chk("rst_we", {24'd0, o_we}, 32'd0);
    chk("rst_val2", {24'd0, o_val[2]}, 32'd0);
    chk("rst_cts", {31'd0, clear_to_send}, 32'd0);
    chk("rst_xdone", {31'd0, exchange_done}, 32'd0);
    chk("rst_cdone", {31'd0, cycle_done}, 32'd0);
    chk("rst_drop", {31'd0, dropped}, 32'd0);
    chk("rst_ready", {31'd0, enq_ready}, 32'd1);
    chk("rst_m_drop", {31'd0, m_dropped}, 32'd0);
    reset_n = 1'b1;
    tick();

    // two links drain in parallel, latency 1
    enq(3'd2, 8'h5A, 8'd3, 8'd7, acc);   chk("t2_acc2", {31'd0, acc}, 32'd1);
    enq(3'd5, 8'h11, 8'd0, 8'd255, acc); chk("t2_acc5", {31'd0, acc}, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_cts", {31'd0, clear_to_send}, 32'd1);
    chk("t2_ready_drain", {31'd0, enq_ready}, 32'd0);
    tick();
    chk("t2_we", {24'd0, o_we}, 32'h24);
    chk("t2_pay2", {8'd0, o_val[2], o_row[2], o_col[2]}, 32'h5A0307);
    chk("t2_pay5", {8'd0, o_val[5], o_row[5], o_col[5]}, 32'h1100FF);
    chk("t2_xdone_early", {31'd0, exchange_done}, 32'd0);
    tick();
    chk("t2_xdone", {31'd0, exchange_done}, 32'd1);
    chk("t2_we_off", {24'd0, o_we}, 32'd0);
    chk("t2_hold", {24'd0, o_val[2]}, 32'h5A);
    tick();
    chk("t2_cdone", {31'd0, cycle_done}, 32'd1);
    tick();
    chk("t2_cdone_off", {31'd0, cycle_done}, 32'd0);
    chk("t2_idle_cts", {31'd0, clear_to_send}, 32'd0);
    chk("t2_idle_xdone", {31'd0, exchange_done}, 32'd0);

    // masked link on edge PE
    m_enq_valid = 1'b1; m_enq_dir = 3'd0; #1;
    chk("t4_ready", {31'd0, m_enq_ready}, 32'd1);
    tick(); m_enq_valid = 1'b0;
    chk("t4_drop", {31'd0, m_dropped}, 32'd1);
    m_flush = 1'b1; tick(); m_flush = 1'b0;
    repeat (8) tick();
    chk("t4_cdone_cnt", m_cd_cnt, 32'd1);
    chk("t4_no_w0", {31'd0, m_w0_seen}, 32'd0);
    chk("t4_val0", {24'd0, m_val[0]}, 32'd0);
    chk("t4_drop_sticky", {31'd0, m_dropped}, 32'd1);

    // full FIFO back-pressure and cts-gated drain
    for (int i = 0; i < 16; i++) begin
      enq(3'd0, 8'h80 + 8'(i), 8'(i), 8'(15 - i), acc);
      chk($sformatf("t3_acc%0d", i), {31'd0, acc}, 32'd1);
    end
    enq(3'd0, 8'hEE, 8'hEE, 8'hEE, acc);
    chk("t3_full", {31'd0, acc}, 32'd0);
    base = wr_cnt0;
    flush = 1'b1; tick(); flush = 1'b0;
    k = 0;
    while (!exchange_done && k < 100) begin
      cts[0] = (k % 2 == 0);
      tick();
      k++;
    end
    cts[0] = 1'b1;
    chk("t3_xdone", {31'd0, exchange_done}, 32'd1);
    chk("t3_wr_cnt", wr_cnt0 - base, 32'd16);
    chk("t3_sb_empty", sbq.size(), 32'd0);
    tick(); tick();

    // hold in WAIT_PEERS until a slow neighbour reports done
    pdone[3] = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("t5_xdone", {31'd0, exchange_done}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t5_wait_cd%0d", i), {31'd0, cycle_done}, 32'd0);
      chk($sformatf("t5_wait_cts%0d", i), {31'd0, clear_to_send}, 32'd1);
    end
    pdone[3] = 1'b1;
    tick();
    chk("t5_cdone", {31'd0, cycle_done}, 32'd1);
    tick();
    chk("t5_cdone_off", {31'd0, cycle_done}, 32'd0);
    chk("t5_idle_cts", {31'd0, clear_to_send}, 32'd0);
    chk("t5_idle_ready", {31'd0, enq_ready}, 32'd1);

    // reset in the middle of DRAIN
    cts = '0;
    for (int i = 1; i <= 4; i++) enq(3'(i), 8'h40 + 8'(i), 8'(i), 8'(i), acc);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    chk("t6_drain", {31'd0, clear_to_send}, 32'd1);
    chk("t6_drain_xd", {31'd0, exchange_done}, 32'd0);
    reset_n = 1'b0;
    sbq.delete();
    tick();
    chk("t6_we", {24'd0, o_we}, 32'd0);
    chk("t6_cts", {31'd0, clear_to_send}, 32'd0);
    reset_n = 1'b1; cts = '1;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("t6_xdone", {31'd0, exchange_done}, 32'd1);
    tick(); tick();
    chk("t6_idle", {31'd0, enq_ready}, 32'd1);
    chk("end_sb_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
